dds_phase_addr_gen: RTL and testbench

//   DDS phase accumulator and address generator that sits directly upstream of the waveform ROMs.
//   - Drives the 10-bit ROM address (square/sine tables, 8-bit data) from a tunable frequency word.
//   - Emits a data_valid strobe aligned to the ROM read latency, feeding the DAC path.
//   - Applies frequency/phase retunes either immediately or glitch-free at a period boundary.

---
 rtl/dds_pkg.sv | 16 +
 rtl/valid_delay_line.sv | 29 ++
 rtl/dds_phase_addr_gen.sv | 161 ++++++++++++++++
 tb/tb_dds_phase_addr_gen.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared types and widths for the DDS phase accumulator / ROM address generator.
package dds_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } dds_state_t;

  localparam int unsigned DDS_ACC_WIDTH  = 32;
  localparam int unsigned DDS_ADDR_WIDTH = 10;

  // One ROM address step per clock at the default widths.
  localparam logic [DDS_ACC_WIDTH-1:0] DDS_FTW_RESET = 32'h0040_0000;

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-depth shift register for a single valid bit. Used to line the address
// valid strobe up with the ROM read data. A clear empties every stage so no
// stale valid can emerge after a reset.
module valid_delay_line #(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic valid_i,
  output logic valid_o
);

  logic [DEPTH-1:0] pipe_q;

  // Shift the valid bit one stage per clock; clear all stages on reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= valid_i;
      for (int i = 1; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign valid_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/dds_phase_addr_gen.sv
// DDS phase accumulator and waveform-ROM address generator. The top ADDR_WIDTH
// bits of the accumulator plus a phase offset form the registered ROM address.
// Retunes can be applied on the next cycle or held in shadow registers until
// the accumulator wraps, so a period never mixes two tuning words.
module dds_phase_addr_gen
  import dds_pkg::*;
#(
  parameter int unsigned          ACC_WIDTH   = DDS_ACC_WIDTH,
  parameter int unsigned          ADDR_WIDTH  = DDS_ADDR_WIDTH,
  parameter int unsigned          ROM_LATENCY = 1,
  parameter logic [ACC_WIDTH-1:0] FTW_RESET   = ACC_WIDTH'(DDS_FTW_RESET)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  cfg_valid_i,
  output logic                  cfg_ready_o,
  input  logic [ACC_WIDTH-1:0]  cfg_ftw_i,
  input  logic [ADDR_WIDTH-1:0] cfg_pofs_i,
  input  logic                  cfg_sync_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  addr_valid_o,
  output logic                  data_valid_o,
  output logic                  wrap_o
);

  dds_state_t            state_q, state_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [ACC_WIDTH-1:0]  ftw_q, ftw_d;
  logic [ADDR_WIDTH-1:0] pofs_q, pofs_d;
  logic [ACC_WIDTH-1:0]  ftwShadow_q, ftwShadow_d;
  logic [ADDR_WIDTH-1:0] pofsShadow_q, pofsShadow_d;
  logic                  carry_q, carry_d;
  logic [ACC_WIDTH:0]    accSum;
  logic                  cfgFire;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  addrValid_q;
  logic                  wrap_q;

  // While a synchronised retune is waiting, no further config can be taken.
  assign cfg_ready_o = (state_q != PEND);
  assign cfgFire     = cfg_valid_i & cfg_ready_o;
  assign accSum      = {1'b0, acc_q} + {1'b0, ftw_q};

  // Next-state logic: accumulate while running and decide where config lands.
  // Dropping enable always wins; any config accepted on that same cycle is
  // applied directly, and a waiting shadow config is thrown away.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    ftw_d        = ftw_q;
    pofs_d       = pofs_q;
    ftwShadow_d  = ftwShadow_q;
    pofsShadow_d = pofsShadow_q;
    carry_d      = 1'b0;
    case (state_q)
      IDLE: begin
        acc_d = '0;
        if (cfgFire) begin
          ftw_d  = cfg_ftw_i;
          pofs_d = cfg_pofs_i;
        end
        if (en_i) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!en_i) begin
          state_d = IDLE;
          acc_d   = '0;
          if (cfgFire) begin
            ftw_d  = cfg_ftw_i;
            pofs_d = cfg_pofs_i;
          end
        end else begin
          acc_d   = accSum[ACC_WIDTH-1:0];
          carry_d = accSum[ACC_WIDTH];
          if (cfgFire) begin
            if (cfg_sync_i) begin
              ftwShadow_d  = cfg_ftw_i;
              pofsShadow_d = cfg_pofs_i;
              state_d      = PEND;
            end else begin
              ftw_d  = cfg_ftw_i;
              pofs_d = cfg_pofs_i;
            end
          end
        end
      end
      PEND: begin
        if (!en_i) begin
          state_d = IDLE;
          acc_d   = '0;
        end else begin
          acc_d   = accSum[ACC_WIDTH-1:0];
          carry_d = accSum[ACC_WIDTH];
          if (accSum[ACC_WIDTH]) begin
            ftw_d   = ftwShadow_q;
            pofs_d  = pofsShadow_q;
            state_d = RUN;
          end
        end
      end
      default: begin
        state_d = IDLE;
        acc_d   = '0;
      end
    endcase
  end

  // Control and accumulator registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      ftw_q        <= FTW_RESET;
      pofs_q       <= '0;
      ftwShadow_q  <= '0;
      pofsShadow_q <= '0;
      carry_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      ftw_q        <= ftw_d;
      pofs_q       <= pofs_d;
      ftwShadow_q  <= ftwShadow_d;
      pofsShadow_q <= pofsShadow_d;
      carry_q      <= carry_d;
    end
  end

  // Output stage: the address is built from the current accumulator, and the
  // wrap flag follows the carry by one clock so it lands on the first sample
  // of the new period (which already uses any offset swapped in at the wrap).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q      <= '0;
      addrValid_q <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      addr_q      <= acc_q[ACC_WIDTH-1 -: ADDR_WIDTH] + pofs_q;
      addrValid_q <= (state_q != IDLE);
      wrap_q      <= carry_q;
    end
  end

  assign addr_o       = addr_q;
  assign addr_valid_o = addrValid_q;
  assign wrap_o       = wrap_q;

  valid_delay_line #(
    .DEPTH(ROM_LATENCY)
  ) u_dataValid (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .valid_i(addrValid_q),
    .valid_o(data_valid_o)
  );

endmodule

// File: tb/tb_dds_phase_addr_gen.sv
// Directed-vector bench for dds_phase_addr_gen. Two instances share all inputs:
// one with a single-cycle ROM latency and one with a two-cycle latency.
module tb_dds_phase_addr_gen;

  typedef struct {
    logic [3:0]  ctl;
    logic [31:0] ftw;
    logic [9:0]  pofs;
    logic [9:0]  eAddr;
    logic [2:0]  eFlags;
  } vec_t;

  localparam logic [3:0] C_RST  = 4'b1000;
  localparam logic [3:0] C_EN   = 4'b0100;
  localparam logic [3:0] C_CV   = 4'b0010;
  localparam logic [3:0] C_SYNC = 4'b0001;
  localparam logic [3:0] C_NONE = 4'b0000;
  localparam logic [2:0] E_AV   = 3'b100;
  localparam logic [2:0] E_WR   = 3'b010;
  localparam logic [2:0] E_RDY  = 3'b001;
  localparam logic [2:0] E_NONE = 3'b000;
  localparam logic [31:0] F0    = 32'h0;
  localparam logic [9:0]  P0    = 10'd0;

  logic        clk;
  logic        rst;
  logic        en;
  logic        cfgValid;
  logic        cfgSync;
  logic [31:0] cfgFtw;
  logic [9:0]  cfgPofs;

  logic        cfgReadyA, cfgReadyB;
  logic [9:0]  addrA, addrB;
  logic        addrValidA, addrValidB;
  logic        dataValidA, dataValidB;
  logic        wrapA, wrapB;

  vec_t        vecs[$];
  int          nVectors = 0;
  int          nMiss    = 0;
  logic        avHist1  = 1'b0;
  logic        avHist2  = 1'b0;

  dds_phase_addr_gen #(.ROM_LATENCY(1)) dutA (
    .clk_i       (clk),
    .rst_i       (rst),
    .en_i        (en),
    .cfg_valid_i (cfgValid),
    .cfg_ready_o (cfgReadyA),
    .cfg_ftw_i   (cfgFtw),
    .cfg_pofs_i  (cfgPofs),
    .cfg_sync_i  (cfgSync),
    .addr_o      (addrA),
    .addr_valid_o(addrValidA),
    .data_valid_o(dataValidA),
    .wrap_o      (wrapA)
  );

  dds_phase_addr_gen #(.ROM_LATENCY(2)) dutB (
    .clk_i       (clk),
    .rst_i       (rst),
    .en_i        (en),
    .cfg_valid_i (cfgValid),
    .cfg_ready_o (cfgReadyB),
    .cfg_ftw_i   (cfgFtw),
    .cfg_pofs_i  (cfgPofs),
    .cfg_sync_i  (cfgSync),
    .addr_o      (addrB),
    .addr_valid_o(addrValidB),
    .data_valid_o(dataValidB),
    .wrap_o      (wrapB)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mkVec(input logic [3:0] c, input logic [31:0] f, input logic [9:0] p,
                                 input logic [9:0] a, input logic [2:0] e);
    vec_t v;
    v.ctl    = c;
    v.ftw    = f;
    v.pofs   = p;
    v.eAddr  = a;
    v.eFlags = e;
    return v;
  endfunction

  function automatic void addVec(input logic [3:0] c, input logic [31:0] f, input logic [9:0] p,
                                 input logic [9:0] a, input logic [2:0] e);
    vecs.push_back(mkVec(c, f, p, a, e));
  endfunction

  task automatic cmp(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
    if (got !== exp) begin
      nMiss++;
      $display("[TB] FAIL %s vec %0d: got %0h expected %0h", name, idx, got, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst      = v.ctl[3];
    en       = v.ctl[2];
    cfgValid = v.ctl[1];
    cfgSync  = v.ctl[0];
    cfgFtw   = v.ftw;
    cfgPofs  = v.pofs;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input vec_t v, input string tag, input int idx);
    logic expDvA;
    logic expDvB;
    expDvA = v.ctl[3] ? 1'b0 : avHist1;
    expDvB = v.ctl[3] ? 1'b0 : avHist2;
    nVectors++;
    cmp({tag, " addrA"},  idx, 32'(addrA),      32'(v.eAddr));
    cmp({tag, " avA"},    idx, 32'(addrValidA), 32'(v.eFlags[2]));
    cmp({tag, " wrapA"},  idx, 32'(wrapA),      32'(v.eFlags[1]));
    cmp({tag, " rdyA"},   idx, 32'(cfgReadyA),  32'(v.eFlags[0]));
    cmp({tag, " dvA"},    idx, 32'(dataValidA), 32'(expDvA));
    cmp({tag, " addrB"},  idx, 32'(addrB),      32'(v.eAddr));
    cmp({tag, " avB"},    idx, 32'(addrValidB), 32'(v.eFlags[2]));
    cmp({tag, " wrapB"},  idx, 32'(wrapB),      32'(v.eFlags[1]));
    cmp({tag, " rdyB"},   idx, 32'(cfgReadyB),  32'(v.eFlags[0]));
    cmp({tag, " dvB"},    idx, 32'(dataValidB), 32'(expDvB));
    avHist2 = v.ctl[3] ? 1'b0 : avHist1;
    avHist1 = v.eFlags[2];
  endtask

  // Build the directed table; each entry's expectation is hand-derived from
  // the accumulator value (in address units) entering that clock edge.
  task automatic buildTable();
    // Reset, start-up latency and the default 1-step ramp.
    addVec(C_RST, F0, P0, 10'd0, E_RDY);
    addVec(C_EN, F0, P0, 10'd0, E_RDY);
    addVec(C_EN, F0, P0, 10'd0, E_AV | E_RDY);
    for (int i = 1; i <= 1022; i++) addVec(C_EN, F0, P0, 10'(i), E_AV | E_RDY);
    // Immediate retune to half-scale on the wrapping edge: 0,512,0,512.
    addVec(C_EN | C_CV, 32'h8000_0000, P0, 10'd1023, E_AV | E_RDY);
    addVec(C_EN, F0, P0, 10'd0,   E_AV | E_WR | E_RDY);
    addVec(C_EN, F0, P0, 10'd512, E_AV | E_RDY);
    addVec(C_EN, F0, P0, 10'd0,   E_AV | E_WR | E_RDY);
    addVec(C_EN, F0, P0, 10'd512, E_AV | E_RDY);
    // Phase offset 256 at unit step; wrap lands on addr 256.
    addVec(C_EN | C_CV, 32'h0040_0000, 10'd256, 10'd0, E_AV | E_WR | E_RDY);
    for (int k = 512; k <= 1023; k++) addVec(C_EN, F0, P0, 10'((k + 256) % 1024), E_AV | E_RDY);
    addVec(C_EN, F0, P0, 10'd256, E_AV | E_WR | E_RDY);
    for (int k = 1; k <= 43; k++) addVec(C_EN, F0, P0, 10'(k + 256), E_AV | E_RDY);
    // Synchronised retune at addr 300; offers during PEND must be ignored.
    addVec(C_EN | C_CV | C_SYNC, 32'h0080_0000, P0, 10'd300, E_AV);
    for (int k = 45; k <= 1022; k++) begin
      addVec(C_EN | (((k >= 100) && (k < 200)) ? C_CV : C_NONE), 32'h0123_4567, 10'd99,
             10'((k + 256) % 1024), E_AV);
    end
    addVec(C_EN, F0, P0, 10'd255, E_AV | E_RDY);
    addVec(C_EN, F0, P0, 10'd0, E_AV | E_WR | E_RDY);
    addVec(C_EN, F0, P0, 10'd2, E_AV | E_RDY);
    addVec(C_EN, F0, P0, 10'd4, E_AV | E_RDY);
    // Enable dropped in PEND: shadow discarded, restart with step 2.
    addVec(C_EN | C_CV | C_SYNC, 32'h0100_0000, 10'd5, 10'd6, E_AV);
    addVec(C_NONE, F0, P0, 10'd8, E_AV | E_RDY);
    addVec(C_NONE, F0, P0, 10'd0, E_RDY);
    addVec(C_EN, F0, P0, 10'd0, E_RDY);
    addVec(C_EN, F0, P0, 10'd0, E_AV | E_RDY);
    addVec(C_EN, F0, P0, 10'd2, E_AV | E_RDY);
    addVec(C_EN, F0, P0, 10'd4, E_AV | E_RDY);
    // Config offered as enable falls: accepted and applied directly.
    addVec(C_CV | C_SYNC, 32'h0100_0000, 10'd10, 10'd6, E_AV | E_RDY);
    addVec(C_NONE, F0, P0, 10'd10, E_RDY);
    addVec(C_EN, F0, P0, 10'd10, E_RDY);
    addVec(C_EN, F0, P0, 10'd10, E_AV | E_RDY);
    addVec(C_EN, F0, P0, 10'd14, E_AV | E_RDY);
    addVec(C_EN, F0, P0, 10'd18, E_AV | E_RDY);
    // Zero tuning word: address freezes, a synced retune never lands.
    addVec(C_EN | C_CV, F0, 10'd10, 10'd22, E_AV | E_RDY);
    for (int k = 0; k < 3; k++) addVec(C_EN, F0, P0, 10'd26, E_AV | E_RDY);
    addVec(C_EN | C_CV | C_SYNC, 32'h0040_0000, P0, 10'd26, E_AV);
    for (int k = 0; k < 20; k++) addVec(C_EN, F0, P0, 10'd26, E_AV);
    addVec(C_NONE, F0, P0, 10'd26, E_AV | E_RDY);
    addVec(C_NONE, F0, P0, 10'd10, E_RDY);
    addVec(C_EN, F0, P0, 10'd10, E_RDY);
    addVec(C_EN, F0, P0, 10'd10, E_AV | E_RDY);
    addVec(C_EN, F0, P0, 10'd10, E_AV | E_RDY);
  endtask

  // Reset landing on the edge where a wrap would fire, with data_valid in flight.
  task automatic runResetSequence();
    vec_t seq[$];
    seq.push_back(mkVec(C_RST, F0, P0, 10'd0, E_RDY));
    seq.push_back(mkVec(C_EN | C_CV | C_SYNC, 32'h8000_0000, P0, 10'd0, E_RDY));
    seq.push_back(mkVec(C_EN, F0, P0, 10'd0,   E_AV | E_RDY));
    seq.push_back(mkVec(C_EN, F0, P0, 10'd512, E_AV | E_RDY));
    seq.push_back(mkVec(C_EN, F0, P0, 10'd0,   E_AV | E_WR | E_RDY));
    seq.push_back(mkVec(C_EN, F0, P0, 10'd512, E_AV | E_RDY));
    seq.push_back(mkVec(C_RST | C_EN, F0, P0, 10'd0, E_RDY));
    seq.push_back(mkVec(C_EN, F0, P0, 10'd0, E_RDY));
    seq.push_back(mkVec(C_EN, F0, P0, 10'd0, E_AV | E_RDY));
    seq.push_back(mkVec(C_EN, F0, P0, 10'd1, E_AV | E_RDY));
    seq.push_back(mkVec(C_EN, F0, P0, 10'd2, E_AV | E_RDY));
    foreach (seq[i]) begin
      applyStimulus(seq[i]);
      checkOutput(seq[i], "rstseq", i);
    end
  endtask

  // Main sequence: table first, then the reset corner case, then the summary.
  initial begin
    rst      = 1'b1;
    en       = 1'b0;
    cfgValid = 1'b0;
    cfgSync  = 1'b0;
    cfgFtw   = '0;
    cfgPofs  = '0;
    buildTable();
    #2;
    $display("[TB] applying %0d table vectors", vecs.size());
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], "tbl", i);
    end
    runResetSequence();
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiss);
    $finish;
  end

endmodule
